// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
//   XLEN        : operand/result width
//   op_e        : funct3 encodings of the M-extension ops
//   IDLE/BUSY/FIN : controller state encodings
//   DIV0_QUOT, INT_MIN : special-case result constants
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // funct3[2] separates divide/remainder from multiply
  function automatic logic op_is_div(op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the ID/EX pipeline register and the
// multiply/divide unit.
//   master : pipeline side (drives start, flush, op, a, b, rd_in)
//   slave  : unit side (drives busy, done, result, rd_out)
interface ex_muldiv_unit_if;
  import muldiv_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, op, a, b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, op, a, b, rd_in,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Final result formation for the multiply/divide unit (combinational).
//   raw    : unsigned magnitude result; {hi, lo} product or {rem, quot}
//   sign_a : dividend/multiplicand sign (already zero for unsigned operands)
//   sign_b : divisor/multiplier sign (already zero for unsigned operands)
//   op     : funct3 of the operation
//   result : 32-bit architectural result
module muldiv_sign_fix #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] raw,
  input  logic              sign_a,
  input  logic              sign_b,
  input  muldiv_pkg::op_e   op,
  output logic [XLEN-1:0]   result
);
  import muldiv_pkg::*;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -raw : raw;
    quot   = (sign_a ^ sign_b) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    // Remainder follows the dividend's sign
    rem    = sign_a ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
    result = '0;
    case (op)
      OP_MUL:                      result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = quot;
      default:                     result = rem;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift/add multiply and restoring divide on operand magnitudes,
// with sign correction applied once at completion. Divide-by-zero and
// signed overflow finish straight from IDLE without iterating.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : request (start, flush, op, a, b, rd_in) and
//           response (busy, done, result, rd_out)
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input logic              clk,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int unsigned CW = $clog2(ITER);

  logic [1:0]        state_q, state_d;
  op_e               op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   opa_q, opa_d;   // multiplier, or dividend/quotient shifter
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;   // product, or {rem, -} for divide
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;

  // Accept-side decode
  op_e             op_in;
  logic            sgn_a_in, sgn_b_in;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    op_in    = op_e'(bus.op);
    sgn_a_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.a[XLEN-1];
    sgn_b_in = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && bus.b[XLEN-1];
    abs_a    = sgn_a_in ? -bus.a : bus.a;
    abs_b    = sgn_b_in ? -bus.b : bus.b;
    div_zero = op_is_div(op_in) && (bus.b == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (bus.a == INT_MIN) && (bus.b == '1);
    // funct3[1] selects the remainder flavour among divides
    if (div_zero) begin
      special_res = op_in[1] ? bus.a : DIV0_QUOT;
    end else begin
      special_res = op_in[1] ? '0 : INT_MIN;
    end
  end

  // One radix-2 step of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic              q_bit;
  logic [XLEN-1:0]   new_rem;
  logic [XLEN-1:0]   div_opa;
  logic [2*XLEN-1:0] raw;
  logic [XLEN-1:0]   fixed_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opa_q[0] ? {1'b0, opb_q} : '0);
    mul_acc = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh  = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opb_q};
    q_bit   = ~diff[XLEN];
    new_rem = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_opa = {opa_q[XLEN-2:0], q_bit};
    // Result of the step being taken this cycle, so the last step feeds the fix-up directly
    raw     = op_is_div(op_q) ? {new_rem, div_opa} : mul_acc;
  end

  muldiv_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .raw    (raw),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .op     (op_q),
    .result (fixed_res)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    rd_d     = rd_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d     = op_in;
          rd_d     = bus.rd_in;
          sign_a_d = sgn_a_in;
          sign_b_d = sgn_b_in;
          opa_d    = abs_a;
          opb_d    = abs_b;
          acc_d    = '0;
          count_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = FIN;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (op_is_div(op_q)) begin
          acc_d = {new_rem, acc_q[XLEN-1:0]};
          opa_d = div_opa;
        end else begin
          acc_d = mul_acc;
          opa_d = opa_q >> 1;
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(ITER - 1)) begin
          result_d = fixed_res;
          state_d  = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // Stall is raised in the accept cycle itself so ID/EX holds the operands
  assign bus.busy   = (state_q == BUSY) || ((state_q == IDLE) && bus.start);
  assign bus.done   = (state_q == FIN) && !bus.flush;
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule
